// File: rtl/fight_pkg.sv
// fight_pkg: shared constants for the fight arbiter -- arena geometry, combat
// tuning, player action one-hot encodings, FSM states and winner codes, plus
// small position helpers used by the arbiter.
package fight_pkg;

   localparam int ARENA_W     = 640;
   localparam int SPRITE_W    = 64;
   localparam int X_MAX       = ARENA_W - SPRITE_W;
   localparam int MIN_GAP     = 48;
   localparam int HIT_RANGE   = 80;
   localparam int STEP        = 2;
   localparam int DAMAGE      = 10;
   localparam int SHIELD_COST = 20;
   localparam int MAX_HEALTH  = 100;
   localparam int MAX_SHIELD  = 100;
   localparam int START0      = 100;
   localparam int START1      = 476;

   localparam logic [6:0] WALKING   = 7'b000_0001;
   localparam logic [6:0] PUNCHING  = 7'b000_0010;
   localparam logic [6:0] SHIELDING = 7'b000_0100;
   localparam logic [6:0] STAGGERED = 7'b000_1000;
   localparam logic [6:0] DOWNED    = 7'b001_0000;
   localparam logic [6:0] STANDING  = 7'b010_0000;
   localparam int SHIELD_BIT = 2;
   localparam int DIR_BIT    = 6;

   typedef enum logic {
      FIGHT = 1'b0,
      KO    = 1'b1
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P0   = 2'b01;
   localparam logic [1:0] WIN_P1   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Distance between two sprite positions, widened so it never wraps.
   function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a > b) ? (11'(a) - 11'(b)) : (11'(b) - 11'(a));
   endfunction

   // Candidate position after one step, clamped to the arena.
   // Opposing requests cancel out.
   function automatic logic [9:0] step_x(input logic [9:0] x, input logic left,
                                         input logic right);
      int v;
      v = int'(x);
      if (left && !right)
         v = (v >= STEP) ? v - STEP : 0;
      else if (right && !left)
         v = (v + STEP > X_MAX) ? X_MAX : v + STEP;
      return 10'(v);
   endfunction

endpackage

// File: rtl/fight_arbiter_if.sv
// fight_arbiter_if: request/action bundle from the player FSMs and the
// authoritative game state returned to players, renderer and HUD.
interface fight_arbiter_if;
   logic       restart;
   logic       left_req0, left_req1;
   logic       right_req0, right_req1;
   logic       attack_req0, attack_req1;
   logic [6:0] action0, action1;
   logic [7:0] health0, health1;
   logic [7:0] shield0, shield1;
   logic [9:0] x0, x1;
   logic       hit0, hit1;
   logic       game_over;
   logic [1:0] winner;

   modport master (
      output restart, left_req0, left_req1, right_req0, right_req1,
             attack_req0, attack_req1, action0, action1,
      input  health0, health1, shield0, shield1, x0, x1, hit0, hit1,
             game_over, winner
   );

   modport slave (
      input  restart, left_req0, left_req1, right_req0, right_req1,
             attack_req0, attack_req1, action0, action1,
      output health0, health1, shield0, shield1, x0, x1, hit0, hit1,
             game_over, winner
   );
endinterface

// File: rtl/fighter_meter.sv
// fighter_meter: one player's health and shield registers. A hit either
// drains the shield (when shielding with charge left) or costs health; a
// recharge tick tops the shield up by one unless the player is shielding
// or took a hit this cycle. health_nxt lets the arbiter see a KO coming.
module fighter_meter
   import fight_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       restore,
   input  logic       enable,
   input  logic       hit,
   input  logic       shielding,
   input  logic       recharge,
   output logic [7:0] health,
   output logic [7:0] shield,
   output logic [7:0] health_nxt
);

   logic [7:0] shield_nxt;

   // Resolve this cycle's hit or recharge into saturated next values
   always_comb begin
      health_nxt = health;
      shield_nxt = shield;
      if (hit) begin
         if (shielding && shield != 8'd0)
            shield_nxt = (shield > 8'(SHIELD_COST)) ? shield - 8'(SHIELD_COST) : 8'd0;
         else
            health_nxt = (health > 8'(DAMAGE)) ? health - 8'(DAMAGE) : 8'd0;
      end else if (recharge && !shielding) begin
         shield_nxt = (shield < 8'(MAX_SHIELD)) ? shield + 8'd1 : 8'(MAX_SHIELD);
      end
   end

   // Meter registers: full on reset or new round, frozen outside the fight
   always_ff @(posedge clk) begin
      if (reset || restore) begin
         health <= 8'(MAX_HEALTH);
         shield <= 8'(MAX_SHIELD);
      end else if (enable) begin
         health <= health_nxt;
         shield <= shield_nxt;
      end
   end

endmodule

// File: rtl/fight_arbiter.sv
// fight_arbiter: owns player positions, resolves attacks and movement,
// runs the FIGHT/KO round FSM and reports health, shield, hits and winner.
// Optional build macro HIT_STUN_EN: a hit player ignores move and attack
// requests for STUN_CYCLES clocks, restarted by every new hit.
module fight_arbiter
   import fight_pkg::*;
#(
   parameter int MOVE_DIV     = 200000,
   parameter int RECHARGE_DIV = 1000000
`ifdef HIT_STUN_EN
   ,
   parameter int STUN_CYCLES  = 25000000
`endif
) (
   input logic            clk,
   input logic            reset,
   fight_arbiter_if.slave bus
);

   state_t      state, state_nxt;
   logic [1:0]  winner_q, winner_nxt;
   logic [9:0]  x0_q, x1_q, x0_nxt, x1_nxt, cand0, cand1;
   logic [31:0] move_cnt, rech_cnt;
   logic        hit0_q, hit1_q;
   logic        fighting, restore, move_tick, rech_tick;
   logic        shield_act0, shield_act1, stun0, stun1;
   logic        in_range, faces0, faces1, hit_to0, hit_to1;
   logic [7:0]  health0, health1, shield0, shield1, health0_nxt, health1_nxt;
   logic        unused_action;

   assign fighting    = (state == FIGHT);
   assign restore     = (state == KO) && bus.restart;
   assign move_tick   = fighting && (move_cnt == 32'(MOVE_DIV - 1));
   assign rech_tick   = fighting && (rech_cnt == 32'(RECHARGE_DIV - 1));
   assign shield_act0 = bus.action0[SHIELD_BIT];
   assign shield_act1 = bus.action1[SHIELD_BIT];

   assign in_range = abs_diff(x0_q, x1_q) <= 11'(HIT_RANGE);
   assign faces0   = (x1_q > x0_q) ? ~bus.action0[DIR_BIT] : bus.action0[DIR_BIT];
   assign faces1   = (x0_q > x1_q) ? ~bus.action1[DIR_BIT] : bus.action1[DIR_BIT];
   assign hit_to1  = fighting && bus.attack_req0 && !stun0 && in_range && faces0;
   assign hit_to0  = fighting && bus.attack_req1 && !stun1 && in_range && faces1;

   assign unused_action = ^{bus.action0[5:3], bus.action0[1:0],
                            bus.action1[5:3], bus.action1[1:0]};

   fighter_meter u_meter0 (
      .clk        (clk),
      .reset      (reset),
      .restore    (restore),
      .enable     (fighting),
      .hit        (hit_to0),
      .shielding  (shield_act0),
      .recharge   (rech_tick),
      .health     (health0),
      .shield     (shield0),
      .health_nxt (health0_nxt)
   );

   fighter_meter u_meter1 (
      .clk        (clk),
      .reset      (reset),
      .restore    (restore),
      .enable     (fighting),
      .hit        (hit_to1),
      .shielding  (shield_act1),
      .recharge   (rech_tick),
      .health     (health1),
      .shield     (shield1),
      .health_nxt (health1_nxt)
   );

`ifdef HIT_STUN_EN
   logic [31:0] stun0_cnt, stun1_cnt;

   // Stun timers reload on each hit and count down to release the player
   always_ff @(posedge clk) begin
      if (reset || restore) begin
         stun0_cnt <= '0;
         stun1_cnt <= '0;
      end else if (fighting) begin
         if (hit_to0)
            stun0_cnt <= 32'(STUN_CYCLES);
         else if (stun0_cnt != '0)
            stun0_cnt <= stun0_cnt - 32'd1;
         if (hit_to1)
            stun1_cnt <= 32'(STUN_CYCLES);
         else if (stun1_cnt != '0)
            stun1_cnt <= stun1_cnt - 32'd1;
      end
   end

   assign stun0 = (stun0_cnt != '0);
   assign stun1 = (stun1_cnt != '0);
`else
   assign stun0 = 1'b0;
   assign stun1 = 1'b0;
`endif

   // Move p0 first, then p1 against p0's new spot so they never overlap
   always_comb begin
      x0_nxt = x0_q;
      x1_nxt = x1_q;
      cand0  = step_x(x0_q, bus.left_req0 && !stun0, bus.right_req0 && !stun0);
      if (move_tick && !shield_act0 && abs_diff(cand0, x1_q) >= 11'(MIN_GAP))
         x0_nxt = cand0;
      cand1  = step_x(x1_q, bus.left_req1 && !stun1, bus.right_req1 && !stun1);
      if (move_tick && !shield_act1 && abs_diff(cand1, x0_nxt) >= 11'(MIN_GAP))
         x1_nxt = cand1;
   end

   // Round FSM: enter KO when a health hits zero, leave only on restart
   always_comb begin
      state_nxt  = state;
      winner_nxt = winner_q;
      case (state)
         FIGHT: begin
            if (health0_nxt == 8'd0 && health1_nxt == 8'd0) begin
               state_nxt  = KO;
               winner_nxt = WIN_DRAW;
            end else if (health1_nxt == 8'd0) begin
               state_nxt  = KO;
               winner_nxt = WIN_P0;
            end else if (health0_nxt == 8'd0) begin
               state_nxt  = KO;
               winner_nxt = WIN_P1;
            end
         end
         KO: begin
            if (bus.restart) begin
               state_nxt  = FIGHT;
               winner_nxt = WIN_NONE;
            end
         end
         default: begin
            state_nxt  = FIGHT;
            winner_nxt = WIN_NONE;
         end
      endcase
   end

   // FSM state and latched winner
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FIGHT;
         winner_q <= WIN_NONE;
      end else begin
         state    <= state_nxt;
         winner_q <= winner_nxt;
      end
   end

   // Positions, tick counters and hit pulses; everything holds during KO
   always_ff @(posedge clk) begin
      if (reset || restore) begin
         x0_q     <= 10'(START0);
         x1_q     <= 10'(START1);
         move_cnt <= '0;
         rech_cnt <= '0;
         hit0_q   <= 1'b0;
         hit1_q   <= 1'b0;
      end else if (fighting) begin
         x0_q     <= x0_nxt;
         x1_q     <= x1_nxt;
         move_cnt <= move_tick ? '0 : move_cnt + 32'd1;
         rech_cnt <= rech_tick ? '0 : rech_cnt + 32'd1;
         hit0_q   <= hit_to0 && (state_nxt == FIGHT);
         hit1_q   <= hit_to1 && (state_nxt == FIGHT);
      end else begin
         hit0_q   <= 1'b0;
         hit1_q   <= 1'b0;
      end
   end

   assign bus.health0   = health0;
   assign bus.health1   = health1;
   assign bus.shield0   = shield0;
   assign bus.shield1   = shield1;
   assign bus.x0        = x0_q;
   assign bus.x1        = x1_q;
   assign bus.hit0      = hit0_q;
   assign bus.hit1      = hit1_q;
   assign bus.game_over = (state == KO);
   assign bus.winner    = winner_q;

endmodule

// File: tb/tb_fight_arbiter.sv
// tb_fight_arbiter: directed scenarios for the fight arbiter with fast
// tick dividers (move every 4 clocks, recharge every 8). Build with
// HIT_STUN_EN defined to exercise the stun window (40 clocks here).
module tb_fight_arbiter;

   localparam logic [6:0] ACT_R        = 7'b010_0000;
   localparam logic [6:0] ACT_L        = 7'b110_0000;
   localparam logic [6:0] ACT_L_SHIELD = 7'b100_0100;
   localparam logic [6:0] ACT_R_SHIELD = 7'b000_0100;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails  = 0;

   fight_arbiter_if bus ();

   fight_arbiter #(
      .MOVE_DIV     (4),
      .RECHARGE_DIV (8)
`ifdef HIT_STUN_EN
      ,
      .STUN_CYCLES  (40)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic clear_reqs();
      bus.left_req0   = 1'b0;
      bus.left_req1   = 1'b0;
      bus.right_req0  = 1'b0;
      bus.right_req1  = 1'b0;
      bus.attack_req0 = 1'b0;
      bus.attack_req1 = 1'b0;
      bus.restart     = 1'b0;
   endtask

   // Steer both players toward target positions; ok=0 if the budget runs out
   task automatic move_to(input logic [9:0] t0, input logic [9:0] t1, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         bus.right_req0 = (bus.x0 < t0);
         bus.left_req0  = (bus.x0 > t0);
         bus.right_req1 = (bus.x1 < t1);
         bus.left_req1  = (bus.x1 > t1);
         if (bus.x0 == t0 && bus.x1 == t1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      clear_reqs();
   endtask

   task automatic pulse_attack0();
      bus.attack_req0 = 1'b1;
      @(negedge clk);
      bus.attack_req0 = 1'b0;
   endtask

   task automatic pulse_attack1();
      bus.attack_req1 = 1'b1;
      @(negedge clk);
      bus.attack_req1 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.attack_req0 = 1'b1;
      bus.right_req0  = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      clear_reqs();
      checks++; if (bus.health0 !== 8'd100) begin fails++; $display("[TB] FAIL reset_health0 got %0d want 100", bus.health0); end
      checks++; if (bus.health1 !== 8'd100) begin fails++; $display("[TB] FAIL reset_health1 got %0d want 100", bus.health1); end
      checks++; if (bus.shield0 !== 8'd100) begin fails++; $display("[TB] FAIL reset_shield0 got %0d want 100", bus.shield0); end
      checks++; if (bus.shield1 !== 8'd100) begin fails++; $display("[TB] FAIL reset_shield1 got %0d want 100", bus.shield1); end
      checks++; if (bus.x0 !== 10'd100) begin fails++; $display("[TB] FAIL reset_x0 got %0d want 100", bus.x0); end
      checks++; if (bus.x1 !== 10'd476) begin fails++; $display("[TB] FAIL reset_x1 got %0d want 476", bus.x1); end
      checks++; if (bus.winner !== 2'b00) begin fails++; $display("[TB] FAIL reset_winner got %0d want 0", bus.winner); end
      checks++; if (bus.game_over !== 1'b0) begin fails++; $display("[TB] FAIL reset_game_over got %0d want 0", bus.game_over); end
      checks++; if (bus.hit1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_hit1 got %0d want 0", bus.hit1); end
   endtask

   task automatic test_movement();
      bit ok;
      bus.right_req0 = 1'b1;
      bus.left_req1  = 1'b1;
      repeat (40) @(negedge clk);
      clear_reqs();
      checks++; if (bus.x0 !== 10'd120) begin fails++; $display("[TB] FAIL move_rate_x0 got %0d want 120", bus.x0); end
      checks++; if (bus.x1 !== 10'd456) begin fails++; $display("[TB] FAIL move_rate_x1 got %0d want 456", bus.x1); end
      move_to(10'd300, 10'd360, ok);
      checks++; if (!ok) begin fails++; $display("[TB] FAIL move_to_range timeout x0=%0d x1=%0d want 300/360", bus.x0, bus.x1); end
   endtask

   task automatic test_attack();
      pulse_attack0();
      checks++; if (bus.hit1 !== 1'b1) begin fails++; $display("[TB] FAIL attack_hit1 got %0d want 1", bus.hit1); end
      checks++; if (bus.health1 !== 8'd90) begin fails++; $display("[TB] FAIL attack_health1 got %0d want 90", bus.health1); end
      checks++; if (bus.hit0 !== 1'b0) begin fails++; $display("[TB] FAIL attack_hit0 got %0d want 0", bus.hit0); end
      @(negedge clk);
      checks++; if (bus.hit1 !== 1'b0) begin fails++; $display("[TB] FAIL attack_hit1_pulse got %0d want 0", bus.hit1); end
      bus.action0 = ACT_L;
      pulse_attack0();
      bus.action0 = ACT_R;
      checks++; if (bus.health1 !== 8'd90) begin fails++; $display("[TB] FAIL facing_away_health1 got %0d want 90", bus.health1); end
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      checks++; if (bus.health1 !== 8'd90) begin fails++; $display("[TB] FAIL restart_in_fight_health1 got %0d want 90", bus.health1); end
   endtask

   task automatic test_shield();
      logic [7:0] exp_sh [5] = '{8'd80, 8'd60, 8'd40, 8'd20, 8'd0};
      bit ok;
      bus.action1 = ACT_L_SHIELD;
      for (int k = 0; k < 5; k++) begin
         pulse_attack0();
         checks++; if (bus.shield1 !== exp_sh[k]) begin fails++; $display("[TB] FAIL shielded_hit%0d_shield1 got %0d want %0d", k, bus.shield1, exp_sh[k]); end
         checks++; if (bus.health1 !== 8'd90) begin fails++; $display("[TB] FAIL shielded_hit%0d_health1 got %0d want 90", k, bus.health1); end
         @(negedge clk);
      end
      bus.action1 = ACT_L;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.shield1 == 8'd10) begin
            ok = 1'b1;
            break;
         end
      end
      bus.action1 = ACT_L_SHIELD;
      checks++; if (!ok) begin fails++; $display("[TB] FAIL recharge_to_10 timeout shield1=%0d want 10", bus.shield1); end
      pulse_attack0();
      checks++; if (bus.shield1 !== 8'd0) begin fails++; $display("[TB] FAIL shield_sat_shield1 got %0d want 0", bus.shield1); end
      checks++; if (bus.health1 !== 8'd90) begin fails++; $display("[TB] FAIL shield_sat_health1 got %0d want 90", bus.health1); end
      @(negedge clk);
      pulse_attack0();
      checks++; if (bus.health1 !== 8'd80) begin fails++; $display("[TB] FAIL empty_shield_health1 got %0d want 80", bus.health1); end
      checks++; if (bus.hit1 !== 1'b1) begin fails++; $display("[TB] FAIL empty_shield_hit1 got %0d want 1", bus.hit1); end
      bus.action1 = ACT_L;
      @(negedge clk);
   endtask

   task automatic test_gap();
      bus.right_req0 = 1'b1;
      repeat (40) @(negedge clk);
      clear_reqs();
      checks++; if (bus.x0 !== 10'd312) begin fails++; $display("[TB] FAIL gap_x0 got %0d want 312", bus.x0); end
      bus.left_req1 = 1'b1;
      repeat (20) @(negedge clk);
      clear_reqs();
      checks++; if (bus.x1 !== 10'd360) begin fails++; $display("[TB] FAIL gap_x1 got %0d want 360", bus.x1); end
      bus.action0   = ACT_R_SHIELD;
      bus.left_req0 = 1'b1;
      repeat (20) @(negedge clk);
      clear_reqs();
      bus.action0 = ACT_R;
      checks++; if (bus.x0 !== 10'd312) begin fails++; $display("[TB] FAIL shield_no_move_x0 got %0d want 312", bus.x0); end
      bus.left_req1  = 1'b1;
      bus.right_req1 = 1'b1;
      repeat (20) @(negedge clk);
      clear_reqs();
      checks++; if (bus.x1 !== 10'd360) begin fails++; $display("[TB] FAIL both_dirs_x1 got %0d want 360", bus.x1); end
      bus.left_req0  = 1'b1;
      bus.right_req1 = 1'b1;
      repeat (700) @(negedge clk);
      clear_reqs();
      checks++; if (bus.x0 !== 10'd0) begin fails++; $display("[TB] FAIL clamp_left_x0 got %0d want 0", bus.x0); end
      checks++; if (bus.x1 !== 10'd576) begin fails++; $display("[TB] FAIL clamp_right_x1 got %0d want 576", bus.x1); end
   endtask

   task automatic test_double_ko();
      bit ok;
      move_to(10'd300, 10'd360, ok);
      checks++; if (!ok) begin fails++; $display("[TB] FAIL ko_move timeout x0=%0d x1=%0d want 300/360", bus.x0, bus.x1); end
      for (int k = 0; k < 9; k++) begin pulse_attack1(); @(negedge clk); end
      for (int k = 0; k < 7; k++) begin pulse_attack0(); @(negedge clk); end
      checks++; if (bus.health0 !== 8'd10) begin fails++; $display("[TB] FAIL pre_ko_health0 got %0d want 10", bus.health0); end
      checks++; if (bus.health1 !== 8'd10) begin fails++; $display("[TB] FAIL pre_ko_health1 got %0d want 10", bus.health1); end
      bus.attack_req0 = 1'b1;
      bus.attack_req1 = 1'b1;
      @(negedge clk);
      clear_reqs();
      checks++; if (bus.health0 !== 8'd0) begin fails++; $display("[TB] FAIL draw_health0 got %0d want 0", bus.health0); end
      checks++; if (bus.health1 !== 8'd0) begin fails++; $display("[TB] FAIL draw_health1 got %0d want 0", bus.health1); end
      checks++; if (bus.game_over !== 1'b1) begin fails++; $display("[TB] FAIL draw_game_over got %0d want 1", bus.game_over); end
      checks++; if (bus.winner !== 2'b11) begin fails++; $display("[TB] FAIL draw_winner got %0d want 3", bus.winner); end
      bus.right_req0  = 1'b1;
      bus.attack_req1 = 1'b1;
      repeat (10) @(negedge clk);
      clear_reqs();
      checks++; if (bus.x0 !== 10'd300) begin fails++; $display("[TB] FAIL ko_frozen_x0 got %0d want 300", bus.x0); end
      checks++; if (bus.hit0 !== 1'b0) begin fails++; $display("[TB] FAIL ko_hit0 got %0d want 0", bus.hit0); end
      checks++; if (bus.winner !== 2'b11) begin fails++; $display("[TB] FAIL ko_winner_held got %0d want 3", bus.winner); end
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
      checks++; if (bus.health0 !== 8'd100 || bus.health1 !== 8'd100) begin fails++; $display("[TB] FAIL restart_health got %0d/%0d want 100/100", bus.health0, bus.health1); end
      checks++; if (bus.shield0 !== 8'd100 || bus.shield1 !== 8'd100) begin fails++; $display("[TB] FAIL restart_shield got %0d/%0d want 100/100", bus.shield0, bus.shield1); end
      checks++; if (bus.x0 !== 10'd100 || bus.x1 !== 10'd476) begin fails++; $display("[TB] FAIL restart_x got %0d/%0d want 100/476", bus.x0, bus.x1); end
      checks++; if (bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin fails++; $display("[TB] FAIL restart_status got go=%0d win=%0d want 0/0", bus.game_over, bus.winner); end
   endtask

   task automatic test_single_ko();
      bit ok;
      move_to(10'd300, 10'd360, ok);
      checks++; if (!ok) begin fails++; $display("[TB] FAIL p1win_move timeout x0=%0d x1=%0d want 300/360", bus.x0, bus.x1); end
      for (int k = 0; k < 9; k++) begin pulse_attack1(); @(negedge clk); end
      checks++; if (bus.game_over !== 1'b0 || bus.health0 !== 8'd10) begin fails++; $display("[TB] FAIL p1win_pre got go=%0d h0=%0d want 0/10", bus.game_over, bus.health0); end
      pulse_attack1();
      checks++; if (bus.winner !== 2'b10) begin fails++; $display("[TB] FAIL p1win_winner got %0d want 2", bus.winner); end
      checks++; if (bus.game_over !== 1'b1 || bus.health1 !== 8'd100) begin fails++; $display("[TB] FAIL p1win_state got go=%0d h1=%0d want 1/100", bus.game_over, bus.health1); end
      bus.restart = 1'b1;
      @(negedge clk);
      bus.restart = 1'b0;
   endtask

   task automatic test_stun();
      bit ok;
      move_to(10'd300, 10'd360, ok);
      checks++; if (!ok) begin fails++; $display("[TB] FAIL stun_move timeout x0=%0d x1=%0d want 300/360", bus.x0, bus.x1); end
      pulse_attack0();
      checks++; if (bus.hit1 !== 1'b1) begin fails++; $display("[TB] FAIL stun_hit1 got %0d want 1", bus.hit1); end
      pulse_attack1();
`ifdef HIT_STUN_EN
      checks++; if (bus.health0 !== 8'd100) begin fails++; $display("[TB] FAIL stun_attack_health0 got %0d want 100", bus.health0); end
`else
      checks++; if (bus.health0 !== 8'd90) begin fails++; $display("[TB] FAIL nostun_attack_health0 got %0d want 90", bus.health0); end
`endif
      bus.right_req1 = 1'b1;
      repeat (20) @(negedge clk);
`ifdef HIT_STUN_EN
      checks++; if (bus.x1 !== 10'd360) begin fails++; $display("[TB] FAIL stun_hold_x1 got %0d want 360", bus.x1); end
      repeat (60) @(negedge clk);
      checks++; if (!(bus.x1 > 10'd360)) begin fails++; $display("[TB] FAIL stun_release_x1 got %0d want above 360", bus.x1); end
`else
      checks++; if (!(bus.x1 > 10'd360)) begin fails++; $display("[TB] FAIL nostun_move_x1 got %0d want above 360", bus.x1); end
`endif
      clear_reqs();
   endtask

   initial begin
      clear_reqs();
      bus.action0 = ACT_R;
      bus.action1 = ACT_L;
      reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_movement();
      test_attack();
      test_shield();
      test_gap();
      test_double_ko();
      test_single_ko();
      test_stun();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
